// File: rtl/uart_tx_ctrl.sv
`timescale 1ns/1ps
// uart_tx_ctrl: FIFO-buffered UART transmitter with a valid/ready input
// stream, runtime baud divisor, optional even/odd parity and 1 or 2 stop
// bits. Frame configuration is captured when a word leaves the FIFO, so a
// frame on the line is never affected by later changes on the config pins.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [DATA_WIDTH-1:0]            tx_data_i,
  input  logic                             tx_valid_i,
  output logic                             tx_ready_o,
  input  logic [DIV_WIDTH-1:0]             baud_div_i,
  input  logic [1:0]                       parity_mode_i,
  input  logic                             stop2_i,
  output logic                             tx_busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o,
  output logic                             uart_tx_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH+1);
  localparam int IDX_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // A divisor below 2 cannot form a bit period with a load-and-count-down
  // timer, so it saturates to 2.
  function automatic logic [DIV_WIDTH-1:0] sat_div(input logic [DIV_WIDTH-1:0] d);
    return (d < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : d;
  endfunction

  // Even parity is the XOR of the data bits; odd parity inverts it.
  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;

  state_t                state;
  logic [DIV_WIDTH-1:0]  bit_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic                  stop_idx;

  logic [DATA_WIDTH-1:0] shift_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  stop2_q;

  logic                  push;
  logic                  pop;
  logic                  bit_end;
  logic                  last_stop;
  logic [DIV_WIDTH-1:0]  div_in;
  logic [DATA_WIDTH-1:0] head;

  assign tx_ready_o   = (level != LVL_W'(FIFO_DEPTH));
  assign fifo_level_o = level;
  assign push         = tx_valid_i & tx_ready_o;
  assign bit_end      = (bit_cnt == '0);
  assign last_stop    = (state == STOP) && bit_end && (!stop2_q || stop_idx);
  assign pop          = (level != '0) && ((state == IDLE) || last_stop);
  assign div_in       = sat_div(baud_div_i);
  assign head         = fifo_mem[rd_ptr];

  // FIFO storage: written on every accepted push.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= tx_data_i;
  end

  // FIFO pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Frame datapath: word and frame config captured at pop, data shifted
  // out LSB first at the end of the start bit and of each data bit.
  always_ff @(posedge clk_i) begin
    if (pop) begin
      shift_q   <= head;
      div_q     <= div_in;
      par_en_q  <= parity_mode_i[1] ^ parity_mode_i[0];
      par_bit_q <= parity_of(head, parity_mode_i[1]);
      stop2_q   <= stop2_i;
    end else if (bit_end && ((state == START) || (state == DATA))) begin
      shift_q <= shift_q >> 1;
    end
  end

  // Frame sequencer: bit timer, state transitions and registered line/busy.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      uart_tx_o <= 1'b1;
      tx_busy_o <= 1'b0;
    end else if (pop) begin
      state     <= START;
      bit_cnt   <= div_in - 1'b1;
      stop_idx  <= 1'b0;
      uart_tx_o <= 1'b0;
      tx_busy_o <= 1'b1;
    end else begin
      if (state != IDLE) bit_cnt <= bit_end ? (div_q - 1'b1) : (bit_cnt - 1'b1);
      unique case (state)
        IDLE: begin
          uart_tx_o <= 1'b1;
          tx_busy_o <= 1'b0;
        end
        START: begin
          if (bit_end) begin
            state     <= DATA;
            bit_idx   <= '0;
            uart_tx_o <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == IDX_W'(DATA_WIDTH-1)) begin
              if (par_en_q) begin
                state     <= PARITY;
                uart_tx_o <= par_bit_q;
              end else begin
                state     <= STOP;
                stop_idx  <= 1'b0;
                uart_tx_o <= 1'b1;
              end
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              uart_tx_o <= shift_q[0];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state     <= STOP;
            stop_idx  <= 1'b0;
            uart_tx_o <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              state     <= IDLE;
              tx_busy_o <= 1'b0;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_tx_ctrl: the stimulus side records each accepted
// word with the frame settings it will be sent with; an independent monitor
// watches the serial line, expands the expected frame into per-clock line
// levels and compares whole frames.
module tb_uart_tx_ctrl;

  localparam int DW    = 8;
  localparam int DIVW  = 16;
  localparam int DEPTH = 4;
  localparam int LVLW  = $clog2(DEPTH+1);

  logic            clk_i = 1'b0;
  logic            rst_n_i = 1'b0;
  logic [DW-1:0]   tx_data_i = '0;
  logic            tx_valid_i = 1'b0;
  logic            tx_ready_o;
  logic [DIVW-1:0] baud_div_i = 16'd4;
  logic [1:0]      parity_mode_i = 2'b00;
  logic            stop2_i = 1'b0;
  logic            tx_busy_o;
  logic [LVLW-1:0] fifo_level_o;
  logic            uart_tx_o;

  uart_tx_ctrl #(.DATA_WIDTH(DW), .DIV_WIDTH(DIVW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o), .baud_div_i(baud_div_i), .parity_mode_i(parity_mode_i),
    .stop2_i(stop2_i), .tx_busy_o(tx_busy_o), .fifo_level_o(fifo_level_o),
    .uart_tx_o(uart_tx_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] data;
    int            div;
    int            pmode;
    bit            stop2;
    bit            b2b;
  } item_t;

  item_t exp_q[$];
  logic  wave[$];
  item_t cur;
  int    n_cmp = 0;
  int    n_fail = 0;
  bit    coll = 0;
  bit    need_start = 0;
  int    idx = 0;
  int    bad_idx = -1;
  logic  bad_tx, bad_busy;
  int    frames_done = 0;
  int    n_pushed = 0;
  int    max_level = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Expected line level for every clock of a frame, from the frame rules.
  function automatic void build_wave(input item_t it);
    logic bits[$];
    int dv;
    dv = (it.div < 2) ? 2 : it.div;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(it.data[i]);
    if (it.pmode == 1) bits.push_back(^it.data);
    if (it.pmode == 2) bits.push_back(~^it.data);
    bits.push_back(1'b1);
    if (it.stop2) bits.push_back(1'b1);
    wave.delete();
    foreach (bits[b]) for (int k = 0; k < dv; k++) wave.push_back(bits[b]);
  endfunction

  // Monitor: frames are detected from the falling start edge and compared
  // clock by clock against the head of the expected queue.
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      coll = 0;
      need_start = 0;
      exp_q.delete();
    end else begin
      if (int'(fifo_level_o) > max_level) max_level = int'(fifo_level_o);
      if (!coll) begin
        if (need_start) begin
          need_start = 0;
          check("gap_between_frames", uart_tx_o, 1'b0);
        end
        if (uart_tx_o === 1'b1) begin
          check("idle_busy", tx_busy_o, 1'b0);
        end else if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_start: line low at %0t with no word expected", $time);
        end else begin
          cur = exp_q.pop_front();
          build_wave(cur);
          idx = 0;
          bad_idx = -1;
          coll = 1;
        end
      end
      if (coll) begin
        if (bad_idx < 0 && (uart_tx_o !== wave[idx] || tx_busy_o !== 1'b1)) begin
          bad_idx = idx;
          bad_tx = uart_tx_o;
          bad_busy = tx_busy_o;
        end
        idx++;
        if (idx == wave.size()) begin
          n_cmp++;
          frames_done++;
          if (bad_idx >= 0) begin
            n_fail++;
            $display("FAIL frame%0d data=%0h div=%0d: clock %0d of %0d line=%b busy=%b, expected line=%b busy=1",
                     frames_done, cur.data, cur.div, bad_idx, wave.size(), bad_tx, bad_busy, wave[bad_idx]);
          end
          coll = 0;
          if (exp_q.size() > 0 && exp_q[0].b2b) need_start = 1;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_word(input logic [DW-1:0] d);
    int t;
    item_t it;
    t = 0;
    tx_valid_i = 1'b1;
    while (tx_ready_o !== 1'b1 && t <= 2000) begin
      tx_data_i = DW'($urandom);
      @(posedge clk_i); #1;
      t++;
    end
    if (t > 2000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout: ready stayed 0, word %0h not accepted", d);
      tx_valid_i = 1'b0;
      return;
    end
    if (t > 0) check("level_at_ready_reopen", fifo_level_o, DEPTH-1);
    tx_data_i = d;
    @(posedge clk_i);
    it.data  = d;
    it.div   = int'(baud_div_i);
    it.pmode = int'(parity_mode_i);
    it.stop2 = stop2_i;
    it.b2b   = coll || (exp_q.size() > 0);
    exp_q.push_back(it);
    n_pushed++;
    #1;
    tx_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || coll) && t < 3000) begin
      @(posedge clk_i); #1;
      t++;
    end
    if (t >= 3000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: frames did not drain, %0d still expected", name, exp_q.size());
    end
    repeat (3) begin @(posedge clk_i); #1; end
  endtask

  task automatic count_busy(input string name, input int expv);
    int cnt;
    cnt = 0;
    while (tx_busy_o === 1'b1 && cnt < 2000) begin
      cnt++;
      @(posedge clk_i); #1;
    end
    check(name, cnt, expv);
  endtask

  task automatic set_cfg(input int dv, input int pm, input bit s2);
    baud_div_i = DIVW'(dv);
    parity_mode_i = 2'(pm);
    stop2_i = s2;
  endtask

  initial begin
    int first_drop;
    int accepted;
    int bad_idle;

    repeat (3) @(posedge clk_i);
    #1;
    check("reset_line", uart_tx_o, 1'b1);
    check("reset_busy", tx_busy_o, 1'b0);
    check("reset_ready", tx_ready_o, 1'b1);
    check("reset_level", fifo_level_o, 0);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // 8N1, div 4, 0x55 with latency checks.
    set_cfg(4, 0, 0);
    push_word(8'h55);
    check("level_after_push", fifo_level_o, 1);
    check("line_before_pop", uart_tx_o, 1'b1);
    check("busy_before_pop", tx_busy_o, 1'b0);
    @(posedge clk_i); #1;
    check("level_after_pop", fifo_level_o, 0);
    check("line_at_start", uart_tx_o, 1'b0);
    check("busy_at_start", tx_busy_o, 1'b1);
    count_busy("busy_len_8n1_div4", 40);
    wait_drain("8n1");

    // Even and odd parity, two stop bits, div 3, 0xA5.
    set_cfg(3, 1, 1);
    push_word(8'hA5);
    @(posedge clk_i); #1;
    count_busy("busy_len_8e2_div3", 36);
    wait_drain("8e2");
    set_cfg(3, 2, 1);
    push_word(8'hA5);
    @(posedge clk_i); #1;
    count_busy("busy_len_8o2_div3", 36);
    wait_drain("8o2");

    // Burst of 8 words with valid held.
    set_cfg(4, 0, 0);
    max_level = 0;
    first_drop = -1;
    accepted = 0;
    for (int k = 0; k < 8; k++) begin
      push_word(DW'($urandom));
      accepted++;
      tx_valid_i = 1'b1;
      if (tx_ready_o !== 1'b1 && first_drop < 0) first_drop = accepted;
    end
    tx_valid_i = 1'b0;
    check("burst_accepted_before_full", first_drop, 5);
    wait_drain("burst");
    check("burst_level_within_depth", (max_level <= DEPTH), 1);

    // Config change while a frame is in its data bits.
    set_cfg(4, 0, 0);
    push_word(8'h3C);
    repeat (8) begin @(posedge clk_i); #1; end
    set_cfg(8, 1, 1);
    push_word(8'hC3);
    wait_drain("cfg_change");

    // Divisor 0 and 1 both give 2-clock bits.
    set_cfg(0, 0, 0);
    push_word(DW'($urandom));
    @(posedge clk_i); #1;
    count_busy("busy_len_div0", 20);
    wait_drain("div0");
    set_cfg(1, 0, 0);
    push_word(DW'($urandom));
    @(posedge clk_i); #1;
    count_busy("busy_len_div1", 20);
    wait_drain("div1");

    // Reset in the middle of a frame with three words queued.
    set_cfg(4, 0, 0);
    for (int k = 0; k < 4; k++) push_word(DW'($urandom));
    repeat (6) begin @(posedge clk_i); #1; end
    rst_n_i = 1'b0;
    #1;
    check("midrst_line", uart_tx_o, 1'b1);
    check("midrst_level", fifo_level_o, 0);
    check("midrst_busy", tx_busy_o, 1'b0);
    check("midrst_ready", tx_ready_o, 1'b1);
    repeat (2) begin @(posedge clk_i); #1; end
    rst_n_i = 1'b1;
    bad_idle = 0;
    repeat (30) begin
      @(posedge clk_i); #1;
      if (uart_tx_o !== 1'b1 || tx_busy_o !== 1'b0) bad_idle++;
    end
    check("idle_after_reset_release", bad_idle, 0);

    // Randomized traffic and settings.
    for (int r = 0; r < 16; r++) begin
      if (exp_q.size() == 0 && !coll && $urandom_range(0, 1) == 1)
        set_cfg($urandom_range(2, 6), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 25)) begin @(posedge clk_i); #1; end
      push_word(DW'($urandom));
    end
    wait_drain("random");

    check("frames_completed", frames_done, n_pushed - 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Parametrised UART transmitter with an input FIFO, runtime baud divisor, optional parity and one or two stop bits. Sits between any byte-producing block and the board TX pin. It replaces fixed-rate, single-word, enable-pulse transmitters with a valid/ready stream interface that absorbs bursts without dropping words.

## Interface
- DATA_WIDTH, 8: data bits per frame, legal 5..9, sent LSB first.
- DIV_WIDTH, 16: width of the baud divisor input.
- FIFO_DEPTH, 4: input FIFO entries, power of two, at least 2.

- clk_i  in  1  system clock; all logic is on its rising edge.
- rst_n_i  in  1  reset, asynchronous and active-low.
- tx_data_i  in  DATA_WIDTH  word to transmit.
- tx_valid_i  in  1  tx_data_i is valid.
- tx_ready_o  out  1  FIFO can accept a word; a push happens on a cycle with tx_valid_i & tx_ready_o.
- baud_div_i  in  DIV_WIDTH  clocks per bit (e.g. 5208 for 9600 bps at 50 MHz); values 0 and 1 are treated as 2.
- parity_mode_i  in  2  00 none, 01 even, 10 odd, 11 none.
- stop2_i  in  1  0 selects one stop bit, 1 selects two.
- tx_busy_o  out  1  a frame is on the line.
- fifo_level_o  out  $clog2(FIFO_DEPTH+1)  number of occupied FIFO entries.
- uart_tx_o  out  1  serial line, idle high.

## Operation
- FIFO:
  - tx_ready_o = (fifo_level_o != FIFO_DEPTH), decoded from registered state only. It does not anticipate a same-cycle pop.
  - A push and a pop in the same cycle leave the level unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states are IDLE, START, DATA, PARITY and STOP.
  - IDLE: when the FIFO is non-empty, pop the head word into the shift register. Latch baud_div_i (clamped to at least 2), parity_mode_i and stop2_i. Go to START.
  - START: drive 0 for one bit period, then go to DATA.
  - DATA: drive shift[0] and shift right each bit period. After DATA_WIDTH bits, go to PARITY if parity is enabled, otherwise go to STOP.
  - PARITY: drive the parity bit. Even parity is the XOR of the data bits. Odd parity is the inverse of that XOR.
  - STOP: drive 1 for 1 or 2 bit periods, as latched.
    - At the final cycle of the last stop bit, if the FIFO is non-empty, pop and go directly to START, with no idle cycle.
    - Otherwise go to IDLE.
- Config inputs are sampled only at the pop. Changes mid-frame have no effect on the current frame.
- Bit timer:
  - A down-counter is loaded with div-1 at each bit start.
  - The bit ends on the cycle the counter reads 0.
  - Each bit is exactly div clocks.
- uart_tx_o is registered, with no combinational path from inputs.
- tx_busy_o is registered. It is 1 in START, DATA, PARITY and STOP, and 0 in IDLE.

## Timing
- Reset values: uart_tx_o=1, tx_busy_o=0, tx_ready_o=1, fifo_level_o=0, FSM in IDLE.
- Reset asserted mid-frame: the line goes high immediately and the FIFO is flushed. The partial frame is abandoned.
- Latency with an empty FIFO and FSM in IDLE:
  - Push accepted at edge E0.
  - Pop at E1; uart_tx_o falls and tx_busy_o rises at E1.
  - fifo_level_o reads 1 after E0 and 0 after E1.
- Frame length = (1 + DATA_WIDTH + P + S) × div clocks, where P is 0 or 1 and S is 1 or 2.
- Back-to-back words produce contiguous frames. The next start bit immediately follows the final stop-bit cycle.
- With the FIFO full, tx_ready_o=0. A pop makes tx_ready_o=1 from the following cycle.
- tx_valid_i with tx_ready_o=0 is ignored, and tx_data_i may change freely.

## Test plan
- 8N1, div=4: push 0x55. uart_tx_o reads 0,1,0,1,0,1,0,1,0,1, each bit 4 clocks, 40 clocks total. Start bit begins 1 cycle after the accept edge. tx_busy_o is high for exactly 40 clocks.
- Even parity, two stop bits, div=3: push 0xA5. The line carries 0, bits 1,0,1,0,0,1,0,1, parity 0, then 1,1, for 36 clocks. Repeating with odd parity gives a parity bit of 1.
- Burst with FIFO_DEPTH=4 and tx_valid_i held for 8 words:
  - tx_ready_o drops after the FIFO fills (5 words accepted, 1 in flight).
  - All 8 words appear in order with no idle gap between frames.
  - fifo_level_o never exceeds 4.
- Config change mid-frame: change div from 4 to 8 during the DATA state. The current frame completes at div=4 and the next frame uses div=8.
- Divisor clamp: with baud_div_i=0 and then 1, every bit lasts exactly 2 clocks.
- Reset mid-frame: assert rst_n_i during the DATA state with 3 words queued. uart_tx_o=1, level=0 and tx_busy_o=0 immediately. After release the line stays idle until a new push.
